// File: rtl/cal_pkg.sv
// Shared definitions for the calculator datapath: operator codes, error flag
// bit positions and the default operand width.
package cal_pkg;

    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    localparam int ERR_W    = 4;
    localparam int ERR_UDF  = 0;   // pop on an empty stack
    localparam int ERR_OVF  = 1;   // push on a full stack
    localparam int ERR_DIV0 = 2;   // division by zero
    localparam int ERR_BUSY = 3;   // front-end push dropped by a controller strobe

endpackage

// File: rtl/cal_stack.sv
// Parameterised LIFO used for both the operand and the operator stack.
// A pop and a push in the same cycle act in that order, so together they
// replace the top entry. Popping an empty stack or pushing a full one leaves
// the pointer unchanged and raises the matching one-cycle flag.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   push, push_data   write push_data on top
//   pop               discard the top entry
//   top               current top entry, 0 when empty
//   cnt               number of stored entries
//   empty, full       status derived from the registered pointer
//   overflow          push attempted with no room (after this cycle's pop)
//   underflow         pop attempted on an empty stack
module cal_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] ptr;
    logic [CW-1:0] ptr_m1;
    logic [CW-1:0] ptr_pop;
    logic          push_ok;

    assign empty  = (ptr == '0);
    assign full   = (ptr == CW'(DEPTH));
    assign ptr_m1 = ptr - 1'b1;
    assign top    = empty ? '0 : mem[ptr_m1[AW-1:0]];
    assign cnt    = ptr;

    // Pointer after the pop, so a simultaneous push lands in the freed slot.
    assign ptr_pop   = (pop && !empty) ? ptr_m1 : ptr;
    assign push_ok   = push && (ptr_pop < CW'(DEPTH));
    assign overflow  = push && !push_ok;
    assign underflow = pop && empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_pop + CW'(push_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[ptr_pop[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cal_dp.sv
// Calculator datapath. Holds the operand and operator stacks, the a/b/opc
// operand registers and the ALU. The controller pops b, then a together with
// the operator, then pushes alu(a, opc, b) back while signalling complete.
// Any controller strobe takes the stacks away from the front end for that
// cycle; a front-end push arriving then is dropped and flagged.
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   in_opnd_push, in_opnd_data  front-end operand push
//   in_op_push, in_op_code      front-end operator push
//   opnd_pop, op_pop            controller pops into b / a and opc
//   opnd_push, complete         controller pushes the ALU result / ends evaluation
//   clr_err                     clears the sticky error flags
//   opnd_top, opnd_cnt          operand stack top (0 when empty) and depth
//   opnd_empty .. op_full       stack status
//   result, result_valid        registered result, pulse the cycle after complete
//   err                         sticky {busy, div0, overflow, underflow}
module cal_dp
    import cal_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int OPND_DEPTH = 8,
    parameter int OP_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_opnd_push,
    input  logic [DW-1:0]                 in_opnd_data,
    input  logic                          in_op_push,
    input  logic [1:0]                    in_op_code,
    input  logic                          opnd_pop,
    input  logic                          op_pop,
    input  logic                          opnd_push,
    input  logic                          complete,
    input  logic                          clr_err,
    output logic [DW-1:0]                 opnd_top,
    output logic [$clog2(OPND_DEPTH):0]   opnd_cnt,
    output logic                          opnd_empty,
    output logic                          opnd_full,
    output logic                          op_empty,
    output logic                          op_full,
    output logic [DW-1:0]                 result,
    output logic                          result_valid,
    output logic [ERR_W-1:0]              err
);

    function automatic logic [DW-1:0] alu(input logic [DW-1:0] x,
                                          input op_e           code,
                                          input logic [DW-1:0] y);
        logic [2*DW-1:0] prod;
        prod = x * y;
        case (code)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_MUL:  return prod[DW-1:0];
            OP_DIV:  return (y == '0) ? '1 : x / y;
            default: return '0;
        endcase
    endfunction

    logic                          ctrl_any;
    logic                          fe_opnd_ok;
    logic                          fe_op_ok;
    logic [DW-1:0]                 alu_out;
    logic                          div0;
    logic                          opnd_ovf, opnd_udf, op_ovf, op_udf;
    logic [1:0]                    op_top;
    logic [$clog2(OP_DEPTH):0]     op_cnt_unused;
    logic [ERR_W-1:0]              err_new;
    logic [ERR_W-1:0]              err_q;

    logic [DW-1:0]                 a_p0, b_p0;
    op_e                           opc_p0;
    logic [DW-1:0]                 result_p1;
    logic                          vld_p1;

    assign ctrl_any   = opnd_pop | op_pop | opnd_push | complete;
    assign fe_opnd_ok = in_opnd_push & ~ctrl_any;
    assign fe_op_ok   = in_op_push & ~ctrl_any;

    assign alu_out = alu(a_p0, opc_p0, b_p0);
    // Division by zero is only reported when the result is actually consumed.
    assign div0    = (opnd_push | complete) && (opc_p0 == OP_DIV) && (b_p0 == '0);

    cal_stack #(.W(DW), .DEPTH(OPND_DEPTH)) u_opnd_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (opnd_push | fe_opnd_ok),
        .push_data (opnd_push ? alu_out : in_opnd_data),
        .pop       (opnd_pop),
        .top       (opnd_top),
        .cnt       (opnd_cnt),
        .empty     (opnd_empty),
        .full      (opnd_full),
        .overflow  (opnd_ovf),
        .underflow (opnd_udf)
    );

    cal_stack #(.W(2), .DEPTH(OP_DEPTH)) u_op_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (fe_op_ok),
        .push_data (in_op_code),
        .pop       (op_pop),
        .top       (op_top),
        .cnt       (op_cnt_unused),
        .empty     (op_empty),
        .full      (op_full),
        .overflow  (op_ovf),
        .underflow (op_udf)
    );

    always_comb begin
        err_new           = '0;
        err_new[ERR_UDF]  = opnd_udf | op_udf;
        err_new[ERR_OVF]  = opnd_ovf | op_ovf;
        err_new[ERR_DIV0] = div0;
        err_new[ERR_BUSY] = (in_opnd_push | in_op_push) & ctrl_any;
    end

    // Stage p0: operand registers loaded from the stack tops (0 on underflow).
    // Stage p1: result and its valid pulse, registered with the result push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_p0      <= '0;
            b_p0      <= '0;
            opc_p0    <= OP_ADD;
            result_p1 <= '0;
            vld_p1    <= 1'b0;
            err_q     <= '0;
        end else begin
            if (opnd_pop && op_pop) begin
                a_p0 <= opnd_top;
            end else if (opnd_pop) begin
                b_p0 <= opnd_top;
            end
            if (op_pop) begin
                opc_p0 <= op_e'(op_top);
            end
            if (complete) begin
                result_p1 <= alu_out;
            end
            vld_p1 <= complete;
            // A new error in the clearing cycle still survives.
            err_q  <= clr_err ? err_new : (err_q | err_new);
        end
    end

    assign result       = result_p1;
    assign result_valid = vld_p1;
    assign err          = err_q;

endmodule

// File: tb/tb_cal_dp.sv
module tb_cal_dp;

    localparam int DW         = 8;
    localparam int OPND_DEPTH = 8;
    localparam int OP_DEPTH   = 8;
    localparam int MASK       = (1 << DW) - 1;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        in_opnd_push;
    logic [DW-1:0]               in_opnd_data;
    logic                        in_op_push;
    logic [1:0]                  in_op_code;
    logic                        opnd_pop, op_pop, opnd_push, complete, clr_err;
    logic [DW-1:0]               opnd_top;
    logic [$clog2(OPND_DEPTH):0] opnd_cnt;
    logic                        opnd_empty, opnd_full, op_empty, op_full;
    logic [DW-1:0]               result;
    logic                        result_valid;
    logic [3:0]                  err;

    always #5 clk = ~clk;

    cal_dp #(.DW(DW), .OPND_DEPTH(OPND_DEPTH), .OP_DEPTH(OP_DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_opnd_push (in_opnd_push),
        .in_opnd_data (in_opnd_data),
        .in_op_push   (in_op_push),
        .in_op_code   (in_op_code),
        .opnd_pop     (opnd_pop),
        .op_pop       (op_pop),
        .opnd_push    (opnd_push),
        .complete     (complete),
        .clr_err      (clr_err),
        .opnd_top     (opnd_top),
        .opnd_cnt     (opnd_cnt),
        .opnd_empty   (opnd_empty),
        .opnd_full    (opnd_full),
        .op_empty     (op_empty),
        .op_full      (op_full),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: stacks as queues, ALU in plain integer arithmetic.
    int         m_opnd[$];
    int         m_op[$];
    int         m_a, m_b, m_opc, m_result;
    bit         m_rv;
    logic [3:0] m_err;

    function automatic int ref_alu(input int x, input int code, input int y);
        case (code)
            0:       return (x + y) & MASK;
            1:       return (x - y) & MASK;
            2:       return (x * y) & MASK;
            default: return (y == 0) ? MASK : x / y;
        endcase
    endfunction

    task automatic model_reset();
        m_opnd.delete();
        m_op.delete();
        m_a = 0; m_b = 0; m_opc = 0; m_result = 0; m_rv = 0; m_err = '0;
    endtask

    task automatic model_step();
        logic [3:0] ne;
        bit         ctrl;
        int         av, pv, po, pushv;
        bit         do_push;
        ne   = '0;
        ctrl = opnd_pop | op_pop | opnd_push | complete;
        av   = ref_alu(m_a, m_opc, m_b);
        if ((opnd_push || complete) && m_opc == 3 && m_b == 0) ne[2] = 1'b1;
        pv = 0;
        if (opnd_pop) begin
            if (m_opnd.size() == 0) ne[0] = 1'b1;
            else pv = m_opnd.pop_back();
        end
        po = 0;
        if (op_pop) begin
            if (m_op.size() == 0) ne[0] = 1'b1;
            else po = m_op.pop_back();
        end
        do_push = opnd_push || (in_opnd_push && !ctrl);
        pushv   = opnd_push ? av : int'(in_opnd_data);
        if (do_push) begin
            if (m_opnd.size() < OPND_DEPTH) m_opnd.push_back(pushv);
            else ne[1] = 1'b1;
        end
        if (in_op_push && !ctrl) begin
            if (m_op.size() < OP_DEPTH) m_op.push_back(int'(in_op_code));
            else ne[1] = 1'b1;
        end
        if ((in_opnd_push || in_op_push) && ctrl) ne[3] = 1'b1;
        if (opnd_pop && op_pop) m_a = pv;
        else if (opnd_pop) m_b = pv;
        if (op_pop) m_opc = po;
        m_rv = complete;
        if (complete) m_result = av;
        m_err = clr_err ? ne : (m_err | ne);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":top"},    opnd_top, (m_opnd.size() == 0) ? 0 : m_opnd[$]);
        check({tag, ":cnt"},    opnd_cnt, m_opnd.size());
        check({tag, ":oempty"}, opnd_empty, m_opnd.size() == 0);
        check({tag, ":ofull"},  opnd_full, m_opnd.size() == OPND_DEPTH);
        check({tag, ":pempty"}, op_empty, m_op.size() == 0);
        check({tag, ":pfull"},  op_full, m_op.size() == OP_DEPTH);
        check({tag, ":result"}, result, m_result);
        check({tag, ":rvalid"}, result_valid, m_rv);
        check({tag, ":err"},    err, m_err);
    endtask

    task automatic clear_inputs();
        in_opnd_push = 0; in_opnd_data = '0; in_op_push = 0; in_op_code = '0;
        opnd_pop = 0; op_pop = 0; opnd_push = 0; complete = 0; clr_err = 0;
    endtask

    // Apply current inputs for one edge, then check 1 time unit after it.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
        clear_inputs();
    endtask

    task automatic fe_opnd(input int v);
        in_opnd_push = 1; in_opnd_data = DW'(v); tick("fe_opnd");
    endtask
    task automatic fe_op(input int c);
        in_op_push = 1; in_op_code = 2'(c); tick("fe_op");
    endtask
    task automatic s1();
        opnd_pop = 1; tick("s1");
    endtask
    task automatic s2();
        opnd_pop = 1; op_pop = 1; tick("s2");
    endtask
    task automatic s3();
        opnd_push = 1; complete = 1; tick("s3");
    endtask

    // Reset asserted between edges and checked before the next edge.
    task automatic do_reset();
        clear_inputs();
        reset = 0;
        #2;
        model_reset();
        compare_all("rst");
        reset = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 0;
        model_reset();
        #3;
        compare_all("rst0");
        check("rst0_top_literal", opnd_top, 0);
        check("rst0_empty_literal", {opnd_empty, op_empty, opnd_full, op_full}, 4'b1100);
        #4 reset = 1;
        @(posedge clk); #1;

        // 7 - 3
        fe_opnd(7); fe_opnd(3); fe_op(1);
        s1(); s2(); s3();
        check("sub_result", result, 4);
        check("sub_rvalid", result_valid, 1);
        check("sub_cnt", opnd_cnt, 1);
        check("sub_top", opnd_top, 4);
        check("sub_opempty", op_empty, 1);
        check("sub_err", err, 0);
        tick("idle");
        check("sub_rvalid_drop", result_valid, 0);

        // 20 * 20 wraps, then 144 / 5
        do_reset();
        @(posedge clk); #1;
        fe_opnd(20); fe_opnd(20); fe_op(2);
        s1(); s2(); s3();
        check("mul_result", result, 144);
        fe_opnd(5); fe_op(3);
        s1(); s2(); s3();
        check("div_result", result, 28);

        // Division by zero, then clear
        do_reset();
        @(posedge clk); #1;
        fe_opnd(9); fe_opnd(0); fe_op(3);
        s1(); s2(); s3();
        check("div0_result", result, 255);
        check("div0_err", err, 4'b0100);
        clr_err = 1; tick("clr");
        check("clr_err", err, 0);

        // Underflow on empty, then overflow of operand stack
        do_reset();
        @(posedge clk); #1;
        s1();
        check("udf_cnt", opnd_cnt, 0);
        check("udf_err", err, 4'b0001);
        for (int i = 0; i < 9; i++) fe_opnd(10 + i);
        check("ovf_cnt", opnd_cnt, 8);
        check("ovf_full", opnd_full, 1);
        check("ovf_top", opnd_top, 17);
        check("ovf_err", err, 4'b0011);

        // Front-end push collides with S2
        do_reset();
        @(posedge clk); #1;
        fe_opnd(1); fe_opnd(2); fe_op(0);
        in_opnd_push = 1; in_opnd_data = 8'd99;
        s2();
        check("busy_cnt", opnd_cnt, 1);
        check("busy_err", err, 4'b1000);

        // Reset between S2 and S3 abandons the evaluation
        do_reset();
        @(posedge clk); #1;
        fe_opnd(7); fe_opnd(3); fe_op(1);
        s1(); s2();
        opnd_push = 1; complete = 1;
        reset = 0;
        #2;
        model_reset();
        compare_all("midrst");
        check("midrst_cnt", opnd_cnt, 0);
        @(posedge clk); #1;
        compare_all("midrst_hold");
        clear_inputs();
        reset = 1;
        tick("midrst_rel");
        check("midrst_no_valid", result_valid, 0);
        check("midrst_empty", opnd_empty, 1);

        // Randomised traffic against the model
        do_reset();
        @(posedge clk); #1;
        for (int n = 0; n < 600; n++) begin
            in_opnd_push = ($urandom_range(0, 9) < 4);
            in_opnd_data = ($urandom_range(0, 7) == 0) ? 8'd0 : DW'($urandom_range(0, MASK));
            in_op_push   = ($urandom_range(0, 9) < 3);
            in_op_code   = 2'($urandom_range(0, 3));
            opnd_pop     = ($urandom_range(0, 9) < 2);
            op_pop       = ($urandom_range(0, 9) < 1);
            opnd_push    = ($urandom_range(0, 9) < 1);
            complete     = ($urandom_range(0, 9) < 1);
            clr_err      = ($urandom_range(0, 15) == 0);
            tick("rnd");
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
